// File: rtl/md5_hash_core.sv
// Single-block MD5 engine: pads a 0..MSG_BYTES byte message internally and returns the 128-bit digest.
// Latency 64/ROUNDS_PER_CYCLE + 1 edges from the accepted start to the one-cycle done pulse; start is ignored while busy.
module md5_hash_core #(
    parameter int MSG_BYTES        = 8,
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter int LEN_W            = $clog2(MSG_BYTES + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [8*MSG_BYTES-1:0] msg,
    input  logic [LEN_W-1:0]       msg_len,
    output logic                   busy,
    output logic                   done,
    output logic [127:0]           hash
);

    if (MSG_BYTES < 1 || MSG_BYTES > 55) begin : g_bad_msg_bytes
        $error("md5_hash_core: MSG_BYTES must be in 1..55");
    end
    if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 &&
        ROUNDS_PER_CYCLE != 4 && ROUNDS_PER_CYCLE != 8) begin : g_bad_rounds
        $error("md5_hash_core: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
    end

    localparam logic [31:0] IV_A = 32'h67452301;
    localparam logic [31:0] IV_B = 32'hefcdab89;
    localparam logic [31:0] IV_C = 32'h98badcfe;
    localparam logic [31:0] IV_D = 32'h10325476;

    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL} state_t;

    state_t                 state_q, state_d;
    logic [5:0]             cnt_q, cnt_d;
    logic [31:0]            a_q, b_q, c_q, d_q;
    logic [31:0]            a_d, b_d, c_d, d_d;
    logic [8*MSG_BYTES-1:0] msg_q, msg_d;
    logic [5:0]             len_q, len_d;
    logic [127:0]           hash_q, hash_d;
    logic                   done_q, done_d;

    logic [5:0]             len_c;
    logic [7:0]             blk_b [64];
    logic [31:0]            blk_w [16];
    logic [31:0]            step_a, step_b, step_c, step_d;

    function automatic logic [31:0] k_const(input logic [5:0] i);
        case (i)
            6'd0:  k_const = 32'hd76aa478; 6'd1:  k_const = 32'he8c7b756; 6'd2:  k_const = 32'h242070db; 6'd3:  k_const = 32'hc1bdceee;
            6'd4:  k_const = 32'hf57c0faf; 6'd5:  k_const = 32'h4787c62a; 6'd6:  k_const = 32'ha8304613; 6'd7:  k_const = 32'hfd469501;
            6'd8:  k_const = 32'h698098d8; 6'd9:  k_const = 32'h8b44f7af; 6'd10: k_const = 32'hffff5bb1; 6'd11: k_const = 32'h895cd7be;
            6'd12: k_const = 32'h6b901122; 6'd13: k_const = 32'hfd987193; 6'd14: k_const = 32'ha679438e; 6'd15: k_const = 32'h49b40821;
            6'd16: k_const = 32'hf61e2562; 6'd17: k_const = 32'hc040b340; 6'd18: k_const = 32'h265e5a51; 6'd19: k_const = 32'he9b6c7aa;
            6'd20: k_const = 32'hd62f105d; 6'd21: k_const = 32'h02441453; 6'd22: k_const = 32'hd8a1e681; 6'd23: k_const = 32'he7d3fbc8;
            6'd24: k_const = 32'h21e1cde6; 6'd25: k_const = 32'hc33707d6; 6'd26: k_const = 32'hf4d50d87; 6'd27: k_const = 32'h455a14ed;
            6'd28: k_const = 32'ha9e3e905; 6'd29: k_const = 32'hfcefa3f8; 6'd30: k_const = 32'h676f02d9; 6'd31: k_const = 32'h8d2a4c8a;
            6'd32: k_const = 32'hfffa3942; 6'd33: k_const = 32'h8771f681; 6'd34: k_const = 32'h6d9d6122; 6'd35: k_const = 32'hfde5380c;
            6'd36: k_const = 32'ha4beea44; 6'd37: k_const = 32'h4bdecfa9; 6'd38: k_const = 32'hf6bb4b60; 6'd39: k_const = 32'hbebfbc70;
            6'd40: k_const = 32'h289b7ec6; 6'd41: k_const = 32'heaa127fa; 6'd42: k_const = 32'hd4ef3085; 6'd43: k_const = 32'h04881d05;
            6'd44: k_const = 32'hd9d4d039; 6'd45: k_const = 32'he6db99e5; 6'd46: k_const = 32'h1fa27cf8; 6'd47: k_const = 32'hc4ac5665;
            6'd48: k_const = 32'hf4292244; 6'd49: k_const = 32'h432aff97; 6'd50: k_const = 32'hab9423a7; 6'd51: k_const = 32'hfc93a039;
            6'd52: k_const = 32'h655b59c3; 6'd53: k_const = 32'h8f0ccc92; 6'd54: k_const = 32'hffeff47d; 6'd55: k_const = 32'h85845dd1;
            6'd56: k_const = 32'h6fa87e4f; 6'd57: k_const = 32'hfe2ce6e0; 6'd58: k_const = 32'ha3014314; 6'd59: k_const = 32'h4e0811a1;
            6'd60: k_const = 32'hf7537e82; 6'd61: k_const = 32'hbd3af235; 6'd62: k_const = 32'h2ad7d2bb; default: k_const = 32'heb86d391;
        endcase
    endfunction

    // Shift amount depends only on the round (i[5:4]) and the step position within a group of four.
    function automatic logic [4:0] s_amt(input logic [5:0] i);
        case ({i[5:4], i[1:0]})
            4'd0:  s_amt = 5'd7;  4'd1:  s_amt = 5'd12; 4'd2:  s_amt = 5'd17; 4'd3:  s_amt = 5'd22;
            4'd4:  s_amt = 5'd5;  4'd5:  s_amt = 5'd9;  4'd6:  s_amt = 5'd14; 4'd7:  s_amt = 5'd20;
            4'd8:  s_amt = 5'd4;  4'd9:  s_amt = 5'd11; 4'd10: s_amt = 5'd16; 4'd11: s_amt = 5'd23;
            4'd12: s_amt = 5'd6;  4'd13: s_amt = 5'd10; 4'd14: s_amt = 5'd15; default: s_amt = 5'd21;
        endcase
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] s);
        rotl = (x << s) | (x >> (6'd32 - {1'b0, s}));
    endfunction

    function automatic logic [31:0] bswap(input logic [31:0] x);
        bswap = {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    always_comb begin
        if (32'(msg_len) > 32'(MSG_BYTES)) len_c = 6'(MSG_BYTES);
        else                               len_c = 6'(msg_len);
    end

    // Padded block is rebuilt from the latched message; bytes at or beyond len never reach it.
    always_comb begin
        logic [8:0] bit_len;
        bit_len = {len_q, 3'b000};
        for (int k = 0; k < 64; k++) blk_b[k] = 8'h00;
        for (int k = 0; k < MSG_BYTES; k++) begin
            if (6'(k) < len_q) blk_b[k] = msg_q[8*(MSG_BYTES-k)-1 -: 8];
        end
        for (int k = 0; k < 56; k++) begin
            if (6'(k) == len_q) blk_b[k] = 8'h80;
        end
        blk_b[56] = bit_len[7:0];
        blk_b[57] = {7'b0, bit_len[8]};
        for (int j = 0; j < 16; j++) begin
            blk_w[j] = {blk_b[4*j+3], blk_b[4*j+2], blk_b[4*j+1], blk_b[4*j]};
        end
    end

    always_comb begin
        logic [31:0] a_s, b_s, c_s, d_s, f, sum, tmp;
        logic [5:0]  i;
        logic [3:0]  g;
        a_s = a_q;
        b_s = b_q;
        c_s = c_q;
        d_s = d_q;
        f   = '0;
        sum = '0;
        tmp = '0;
        i   = '0;
        g   = '0;
        for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
            i = cnt_q + 6'(j);
            case (i[5:4])
                2'd0:    begin f = (b_s & c_s) | (~b_s & d_s); g = i[3:0];                 end
                2'd1:    begin f = (d_s & b_s) | (~d_s & c_s); g = i[3:0] * 4'd5 + 4'd1;   end
                2'd2:    begin f = b_s ^ c_s ^ d_s;            g = i[3:0] * 4'd3 + 4'd5;   end
                default: begin f = c_s ^ (b_s | ~d_s);         g = i[3:0] * 4'd7;          end
            endcase
            sum = a_s + f + k_const(i) + blk_w[g];
            tmp = d_s;
            d_s = c_s;
            c_s = b_s;
            b_s = b_s + rotl(sum, s_amt(i));
            a_s = tmp;
        end
        step_a = a_s;
        step_b = b_s;
        step_c = c_s;
        step_d = d_s;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        d_d     = d_q;
        msg_d   = msg_q;
        len_d   = len_q;
        hash_d  = hash_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    msg_d   = msg;
                    len_d   = len_c;
                    a_d     = IV_A;
                    b_d     = IV_B;
                    c_d     = IV_C;
                    d_d     = IV_D;
                    cnt_d   = '0;
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                a_d   = step_a;
                b_d   = step_b;
                c_d   = step_c;
                d_d   = step_d;
                cnt_d = cnt_q + 6'(ROUNDS_PER_CYCLE);
                if (cnt_q + 6'(ROUNDS_PER_CYCLE - 1) == 6'd63) state_d = S_FINAL;
            end
            S_FINAL: begin
                hash_d  = {bswap(IV_A + a_q), bswap(IV_B + b_q), bswap(IV_C + c_q), bswap(IV_D + d_q)};
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            msg_q   <= '0;
            len_q   <= '0;
            hash_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            d_q     <= d_d;
            msg_q   <= msg_d;
            len_q   <= len_d;
            hash_q  <= hash_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hash = hash_q;

endmodule

// File: tb/tb_md5_hash_core.sv
// Scoreboard bench for md5_hash_core: one R=1 and one R=4 instance, both 8-byte builds, checked against a loop-based MD5 model.
module tb_md5_hash_core;

    localparam int LAT1 = 65;
    localparam int LAT4 = 17;

    logic         clk = 1'b0;
    logic         reset;
    logic         start1, start4;
    logic [63:0]  msg1, msg4;
    logic [3:0]   len1, len4;
    logic         busy1, busy4, done1, done4;
    logic [127:0] hash1, hash4;

    int unsigned  cyc = 0;
    int           tests = 0;
    int           fails = 0;

    typedef struct {
        logic [127:0] h;
        int unsigned  due;
    } exp_t;

    exp_t q1[$];
    exp_t q4[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    md5_hash_core #(.MSG_BYTES(8), .ROUNDS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .msg(msg1), .msg_len(len1),
        .busy(busy1), .done(done1), .hash(hash1)
    );

    md5_hash_core #(.MSG_BYTES(8), .ROUNDS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .reset(reset), .start(start4), .msg(msg4), .msg_len(len4),
        .busy(busy4), .done(done4), .hash(hash4)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    // Reference MD5 of a single padded block, straight from the algorithm description.
    function automatic logic [127:0] md5_ref(input logic [63:0] m, input int len_in);
        logic [7:0]  blk [64];
        logic [31:0] w [16];
        logic [31:0] a, b, c, d, f, tmp, x, kk;
        int          sh [4][4];
        int          len, g, s;
        real         r;
        sh = '{'{7, 12, 17, 22}, '{5, 9, 14, 20}, '{4, 11, 16, 23}, '{6, 10, 15, 21}};
        len = (len_in > 8) ? 8 : len_in;
        for (int i = 0; i < 64; i++) blk[i] = 8'h00;
        for (int i = 0; i < len; i++) blk[i] = m[63-8*i -: 8];
        blk[len] = 8'h80;
        blk[56]  = 8'((len * 8) % 256);
        blk[57]  = 8'((len * 8) / 256);
        for (int j = 0; j < 16; j++) w[j] = {blk[4*j+3], blk[4*j+2], blk[4*j+1], blk[4*j]};
        a = 32'h67452301; b = 32'hefcdab89; c = 32'h98badcfe; d = 32'h10325476;
        for (int i = 0; i < 64; i++) begin
            r = $sin(real'(i + 1));
            if (r < 0.0) r = -r;
            kk = 32'(longint'($floor(r * 4294967296.0)));
            if (i < 16)      begin f = (b & c) | (~b & d); g = i;                end
            else if (i < 32) begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
            else if (i < 48) begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
            else             begin f = c ^ (b | ~d);       g = (7 * i) % 16;     end
            s   = sh[i / 16][i % 4];
            x   = a + f + kk + w[g];
            tmp = d;
            d   = c;
            c   = b;
            b   = b + ((x << s) | (x >> (32 - s)));
            a   = tmp;
        end
        a = a + 32'h67452301; b = b + 32'hefcdab89; c = c + 32'h98badcfe; d = d + 32'h10325476;
        return {a[7:0], a[15:8], a[23:16], a[31:24], b[7:0], b[15:8], b[23:16], b[31:24],
                c[7:0], c[15:8], c[23:16], c[31:24], d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!reset && done1) begin
            if (q1.size() == 0) check("spurious_done1", 128'(done1), 128'd0);
            else begin
                e = q1.pop_front();
                check("hash1", hash1, e.h);
                check("latency1", 128'(cyc), 128'(e.due));
                check("busy_in_done1", 128'(busy1), 128'd0);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!reset && done4) begin
            if (q4.size() == 0) check("spurious_done4", 128'(done4), 128'd0);
            else begin
                e = q4.pop_front();
                check("hash4", hash4, e.h);
                check("latency4", 128'(cyc), 128'(e.due));
                check("busy_in_done4", 128'(busy4), 128'd0);
            end
        end
    end

    // Called just after a falling edge; start is sampled on the next rising edge.
    task automatic go(input bit sel, input logic [63:0] m, input logic [3:0] l, input logic [127:0] h);
        exp_t e;
        e.h = h;
        if (!sel) begin
            start1 = 1'b1; msg1 = m; len1 = l;
            e.due = cyc + 1 + LAT1;
            q1.push_back(e);
        end else begin
            start4 = 1'b1; msg4 = m; len4 = l;
            e.due = cyc + 1 + LAT4;
            q4.push_back(e);
        end
        @(negedge clk);
        if (!sel) begin
            start1 = 1'b0; msg1 = {$urandom, $urandom}; len1 = 4'($urandom_range(0, 15));
            check("busy_after_start1", 128'(busy1), 128'd1);
        end else begin
            start4 = 1'b0; msg4 = {$urandom, $urandom}; len4 = 4'($urandom_range(0, 15));
            check("busy_after_start4", 128'(busy4), 128'd1);
        end
    endtask

    task automatic wait_done(input bit sel);
        int n = 0;
        while (!(sel ? done4 : done1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!sel && !done1) check("timeout1", 128'(done1), 128'd1);
        if (sel && !done4)  check("timeout4", 128'(done4), 128'd1);
    endtask

    initial begin
        logic [63:0] m;
        logic [3:0]  l;
        reset = 1'b1;
        start1 = 1'b0; msg1 = '0; len1 = '0;
        start4 = 1'b0; msg4 = '0; len4 = '0;
        repeat (2) @(negedge clk);
        check("reset_busy1", 128'(busy1), 128'd0);
        check("reset_done1", 128'(done1), 128'd0);
        check("reset_hash1", hash1, 128'd0);
        check("reset_hash4", hash4, 128'd0);
        reset = 1'b0;
        @(negedge clk);

        go(1'b0, 64'h0, 4'd0, 128'hd41d8cd98f00b204e9800998ecf8427e);
        wait_done(1'b0);
        m = {24'h616263, 40'hffffffffff};
        go(1'b0, m, 4'd3, 128'h900150983cd24fb0d6963f7d28e17f72);
        wait_done(1'b0);
        @(negedge clk);
        go(1'b0, 64'h3132333435363738, 4'd8, 128'h25d55ad283aa400af464c76d713c07ad);
        wait_done(1'b0);
        go(1'b0, {8'h61, 56'h0}, 4'd1, 128'h0cc175b9c0f1b6a831c399e269772661);
        wait_done(1'b0);
        repeat (3) @(negedge clk);
        check("hash_hold1", hash1, 128'h0cc175b9c0f1b6a831c399e269772661);

        // Restart attempts while busy must not disturb the hash in flight.
        go(1'b0, 64'h3132333435363738, 4'd8, 128'h25d55ad283aa400af464c76d713c07ad);
        repeat (8) @(negedge clk);
        start1 = 1'b1; msg1 = {$urandom, $urandom}; len1 = 4'd5;
        @(negedge clk);
        start1 = 1'b0;
        repeat (19) @(negedge clk);
        start1 = 1'b1; msg1 = {$urandom, $urandom}; len1 = 4'd2;
        @(negedge clk);
        start1 = 1'b0;
        wait_done(1'b0);
        repeat (80) @(negedge clk);

        // Abort mid-hash with reset: no done, outputs cleared.
        m = {$urandom, $urandom};
        go(1'b0, m, 4'd6, md5_ref(m, 6));
        repeat (18) @(negedge clk);
        q1.delete();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy1", 128'(busy1), 128'd0);
        check("abort_hash1", hash1, 128'd0);
        check("abort_done1", 128'(done1), 128'd0);
        repeat (80) @(negedge clk);
        m = {$urandom, $urandom};
        go(1'b0, m, 4'd7, md5_ref(m, 7));
        wait_done(1'b0);

        for (int t = 0; t < 16; t++) begin
            m = {$urandom, $urandom};
            l = 4'($urandom_range(0, 15));
            go(1'b0, m, l, md5_ref(m, int'(l)));
            wait_done(1'b0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        go(1'b1, 64'h3132333435363738, 4'd8, 128'h25d55ad283aa400af464c76d713c07ad);
        wait_done(1'b1);
        @(negedge clk);
        go(1'b1, 64'h3132333435363738, 4'd12, 128'h25d55ad283aa400af464c76d713c07ad);
        wait_done(1'b1);
        for (int t = 0; t < 12; t++) begin
            m = {$urandom, $urandom};
            l = 4'($urandom_range(0, 15));
            go(1'b1, m, l, md5_ref(m, int'(l)));
            wait_done(1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        check("q1_drained", 128'(q1.size()), 128'd0);
        check("q4_drained", 128'(q4.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
